vc_credit_handshake_adapter: RTL

Parametrised successor to the single-VC valid/ready handshake adapter. It accepts flits on a standard valid/ready port tagged with a virtual-channel id and emits them on the NoC side as a registered, one-hot per-VC valid. Per-VC credit counters track free space in the downstream router input buffers. The block sits between a network-interface source and the first router port; it gates acceptance per VC so a stalled VC never blocks the others.

---
 rtl/vc_credit_adapter_pkg.sv | 18 +
 rtl/vc_credit_counter.sv | 37 +++
 rtl/vc_credit_handshake_adapter.sv | 66 ++++++
 3 files changed

// File: rtl/vc_credit_adapter_pkg.sv
// rtl/vc_credit_adapter_pkg.sv - shared helpers and types for the VC credit handshake adapter
package vc_credit_adapter_pkg;

    localparam int MAX_VCS = 64;

    // Per-VC bit vector template; users truncate it to their own VC count.
    typedef logic [MAX_VCS-1:0] credit_vec_t;

    function automatic int credit_width(input int max_credits);
        return (max_credits < 1) ? 1 : $clog2(max_credits + 1);
    endfunction

    // Ids beyond MAX_VCS shift out and yield an all-zero mask.
    function automatic credit_vec_t vc_onehot(input int unsigned id);
        return credit_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// rtl/vc_credit_counter.sv - per-VC saturating credit counter with sticky overflow flag
module vc_credit_counter
    import vc_credit_adapter_pkg::*;
#(
    parameter int MaxCredits = 8,
    parameter int CountWidth = credit_width(MaxCredits)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc,
    input  logic                  dec,
    output logic [CountWidth-1:0] count,
    output logic                  nonzero,
    output logic                  overflow
);

    localparam logic [CountWidth-1:0] FULL = CountWidth'(MaxCredits);

    // A same-cycle credit and accept cancel out, so neither saturation nor underflow applies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == FULL) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/vc_credit_handshake_adapter.sv
// rtl/vc_credit_handshake_adapter.sv - valid/ready source port to credit-based one-hot VC NoC port
module vc_credit_handshake_adapter
    import vc_credit_adapter_pkg::*;
#(
    parameter int DataWidth               = 64,
    parameter int NumberOfVirtualChannels = 4,
    parameter int VirtualChannelIdWidth   = (NumberOfVirtualChannels > 1) ? $clog2(NumberOfVirtualChannels) : 1,
    parameter int MaxCredits              = 8
) (
    input  logic                                                        clk_i,
    input  logic                                                        rst_i,
    input  logic                                                        valid_i,
    output logic                                                        ready_o,
    input  logic [VirtualChannelIdWidth-1:0]                            virtual_channel_id_i,
    input  logic [DataWidth-1:0]                                        data_i,
    output logic [DataWidth-1:0]                                        data_o,
    output logic [NumberOfVirtualChannels-1:0]                          valid_o,
    input  logic [NumberOfVirtualChannels-1:0]                          credit_i,
    output logic [NumberOfVirtualChannels*credit_width(MaxCredits)-1:0] credits_o,
    output logic                                                        credit_overflow_o
);

    localparam int CountWidth = credit_width(MaxCredits);

    logic [NumberOfVirtualChannels-1:0] id_onehot;
    logic [NumberOfVirtualChannels-1:0] vc_nonzero;
    logic [NumberOfVirtualChannels-1:0] vc_overflow;
    logic [NumberOfVirtualChannels-1:0] vc_dec;
    logic                               accept;

    // Out-of-range ids lose their bit in the truncation, which forces ready low.
    assign id_onehot = NumberOfVirtualChannels'(vc_onehot(32'(virtual_channel_id_i)));
    assign ready_o   = |(id_onehot & vc_nonzero);
    assign accept    = valid_i && ready_o;
    assign vc_dec    = accept ? id_onehot : '0;

    for (genvar v = 0; v < NumberOfVirtualChannels; v++) begin : g_vc
        vc_credit_counter #(
            .MaxCredits (MaxCredits),
            .CountWidth (CountWidth)
        ) u_counter (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .inc      (credit_i[v]),
            .dec      (vc_dec[v]),
            .count    (credits_o[v*CountWidth +: CountWidth]),
            .nonzero  (vc_nonzero[v]),
            .overflow (vc_overflow[v])
        );
    end

    assign credit_overflow_o = |vc_overflow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= '0;
            data_o  <= '0;
        end else begin
            valid_o <= vc_dec;
            if (accept) begin
                data_o <= data_i;
            end
        end
    end

endmodule
